// File: rtl/mem_bus_decoder.sv
// mem_bus_decoder: routes one core valid/ready memory port to N_SLAVES slaves
// by an address selector field. Unmapped addresses and requests that wait too
// long get a one-cycle error response. A saturating counter tracks how many
// error responses have been returned. Address, write data and strobes are
// broadcast to the slaves outside this block; only valid, ready and rdata
// pass through here.
module mem_bus_decoder #(
    parameter int unsigned N_SLAVES = 2,
    parameter int unsigned SEL_HI   = 31,
    parameter int unsigned SEL_LO   = 24,
    parameter logic [N_SLAVES*(SEL_HI-SEL_LO+1)-1:0] SLAVE_SEL = {8'h01, 8'h00},
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid,
    input  logic [31:0]              mem_addr,
    output logic                     mem_ready,
    output logic [31:0]              mem_rdata,
    output logic                     bus_err,
    output logic [15:0]              err_count,
    output logic [N_SLAVES-1:0]      s_valid,
    input  logic [N_SLAVES-1:0]      s_ready,
    input  logic [N_SLAVES*32-1:0]   s_rdata
);

    localparam int unsigned SELW  = SEL_HI - SEL_LO + 1;
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam bit          TO_EN = (TIMEOUT != 0);
    // Counter value seen in the last wait cycle before a timeout fires
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ERR  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0]       err_count_q, err_count_d;

    logic [SELW-1:0]     sel_field;
    logic [N_SLAVES-1:0] match;
    logic [N_SLAVES-1:0] onehot;
    logic                hit;
    logic [31:0]         slave_rdata;

    // Only the selector bits of the address are decoded here
    logic unused_addr;
    assign unused_addr = ^mem_addr;

    // Compare the selector field against every slave's programmed value
    always_comb begin
        sel_field = mem_addr[SEL_HI:SEL_LO];
        match     = '0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            match[i] = (sel_field == SLAVE_SEL[i*SELW +: SELW]);
        end
    end

    // Priority pick: lowest matching index wins so duplicates never double-select
    always_comb begin
        onehot = '0;
        hit    = 1'b0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (match[i] && !hit) begin
                onehot[i] = 1'b1;
                hit       = 1'b1;
            end
        end
    end

    // Read data of the selected slave, zero when nothing matches
    always_comb begin
        slave_rdata = '0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (onehot[i]) begin
                slave_rdata = slave_rdata | s_rdata[i*32 +: 32];
            end
        end
    end

    // Next state, wait counter, error counter and the combinational port outputs
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        err_count_d = err_count_q;
        s_valid     = '0;
        mem_ready   = 1'b0;
        mem_rdata   = '0;
        bus_err     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Outputs are gated by rst so a reset drops them without waiting for a clock
                if (!rst) begin
                    s_valid   = {N_SLAVES{mem_valid}} & onehot;
                    mem_ready = |(s_valid & s_ready);
                    mem_rdata = hit ? slave_rdata : 32'h0;
                end

                // Count cycles a live request has waited without a response
                if (!mem_valid || mem_ready) begin
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end

                if (mem_valid && !hit) begin
                    state_d = ST_ERR;
                end else if (TO_EN && mem_valid && !mem_ready && (wait_cnt_q == CNT_LAST)) begin
                    state_d = ST_ERR;
                end
            end

            ST_ERR: begin
                if (!rst) begin
                    mem_ready = 1'b1;
                    mem_rdata = ERR_DATA;
                    bus_err   = 1'b1;
                end
                wait_cnt_d = '0;
                if (err_count_q != 16'hFFFF) begin
                    err_count_d = err_count_q + 16'd1;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // State and counter registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Scoreboard bench for mem_bus_decoder: each request pushes its expected
// response when it is driven; a negedge monitor pops and compares whenever
// the core port sees mem_ready.
module tb_mem_bus_decoder;

    localparam int          TO   = 16;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [1:0]  s_ready;
    logic [63:0] s_rdata;

    logic        mem_ready, bus_err;
    logic [31:0] mem_rdata;
    logic [15:0] err_count;
    logic [1:0]  s_valid;

    logic        mem_ready2, bus_err2;
    logic [31:0] mem_rdata2;
    logic [15:0] err_count2;
    logic [1:0]  s_valid2;

    always #5 clk = ~clk;

    mem_bus_decoder #(
        .N_SLAVES (2),
        .SEL_HI   (31),
        .SEL_LO   (24),
        .SLAVE_SEL({8'h01, 8'h00}),
        .TIMEOUT  (TO),
        .ERR_DATA (ERRD)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .mem_valid(mem_valid),
        .mem_addr (mem_addr),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .bus_err  (bus_err),
        .err_count(err_count),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata)
    );

    // Second instance with duplicate selectors, sharing the same stimulus
    mem_bus_decoder #(
        .N_SLAVES (2),
        .SLAVE_SEL({8'h00, 8'h00})
    ) u_dut_dup (
        .clk      (clk),
        .rst      (rst),
        .mem_valid(mem_valid),
        .mem_addr (mem_addr),
        .mem_ready(mem_ready2),
        .mem_rdata(mem_rdata2),
        .bus_err  (bus_err2),
        .err_count(err_count2),
        .s_valid  (s_valid2),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata)
    );

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];
    logic [15:0] exp_cnt = 16'h0;
    logic [32:0] mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Response monitor: every mem_ready pops one expected response
    always @(negedge clk) begin
        if (!rst && mem_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 32'(mem_ready), 32'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("rdata", mem_rdata, mon_e[31:0]);
                check("bus_err", 32'(bus_err), 32'(mon_e[32]));
                check("err_count", 32'(err_count), 32'(exp_cnt));
                if (mon_e[32] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            end
        end
    end

    task automatic idle(input int n);
        mem_valid = 1'b0;
        s_ready   = 2'b00;
        repeat (n) begin
            @(negedge clk);
            check("idle_ready", 32'(mem_ready), 32'(0));
            check("idle_s_valid", 32'(s_valid), 32'(0));
            @(posedge clk); #1;
        end
    endtask

    // One core request; slaves become ready lat cycles after valid
    task automatic req(input logic [31:0] addr, input int lat, input logic [31:0] rd);
        int         sl;
        bit         hit_e, to_e, got;
        int         done;
        logic [1:0] oh, exp_sv;
        logic [7:0] sel;
        sel   = addr[31:24];
        sl    = (sel == 8'h00) ? 0 : (sel == 8'h01) ? 1 : -1;
        hit_e = (sl >= 0);
        oh    = hit_e ? 2'(1 << sl) : 2'b00;
        to_e  = hit_e && (lat >= TO);
        done  = !hit_e ? 1 : (to_e ? TO : lat);
        got   = 1'b0;
        exp_q.push_back((hit_e && !to_e) ? {1'b0, rd} : {1'b1, ERRD});
        mem_valid = 1'b1;
        mem_addr  = addr;
        s_rdata   = (sl == 1) ? {rd, ~rd} : {~rd, rd};
        for (int cyc = 0; cyc <= done + 1; cyc++) begin
            s_ready = (hit_e && cyc >= lat) ? 2'b11 : 2'b00;
            @(negedge clk);
            exp_sv = (!hit_e || (to_e && cyc == TO)) ? 2'b00 : oh;
            check("s_valid", 32'(s_valid), 32'(exp_sv));
            if (mem_ready) begin
                check("ready_cycle", cyc, done);
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!got) check("ready_seen", 32'(0), 32'(1));
        @(posedge clk); #1;
        s_ready = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0010;
        s_ready   = 2'b11;
        s_rdata   = {32'h2, 32'h1};
        #12;
        check("rst_s_valid", 32'(s_valid), 32'(0));
        check("rst_ready", 32'(mem_ready), 32'(0));
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'(0));
        check("rst_err_count", 32'(err_count), 32'(0));
        mem_valid = 1'b0;
        s_ready   = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Same-cycle ROM read, then RAM write with 3-cycle wait
        req(32'h0000_0010, 0, 32'h13);
        idle(1);
        req(32'h0100_0004, 3, 32'hAA55);
        idle(1);
        check("cnt_after_ok", 32'(err_count), 32'(0));

        // Unmapped access
        req(32'h0200_0000, 0, 32'h0);
        idle(2);
        check("cnt_after_unmapped", 32'(err_count), 32'(1));

        // Unmapped address without valid does nothing
        mem_addr = 32'h0200_0000;
        idle(3);
        check("cnt_no_valid", 32'(err_count), 32'(1));

        // Back-to-back mix without bubbles
        req(32'h0000_0100, 0, 32'h1111_0000);
        req(32'h0100_0200, 0, 32'h2222_0000);
        req(32'h0300_0000, 0, 32'h0);
        req(32'h0000_0000, 0, 32'h0000_0005);
        idle(1);

        // Timeout boundary: ready in last wait cycle succeeds, one later is an error
        req(32'h0000_0040, TO - 1, 32'h77);
        req(32'h0000_0040, TO, 32'h0);
        idle(1);

        // Valid dropped mid-wait restarts the wait count
        mem_valid = 1'b1;
        mem_addr  = 32'h0100_0000;
        s_ready   = 2'b00;
        repeat (10) @(posedge clk);
        #1;
        mem_valid = 1'b0;
        @(negedge clk);
        check("drop_s_valid", 32'(s_valid), 32'(0));
        check("drop_ready", 32'(mem_ready), 32'(0));
        @(posedge clk); #1;
        req(32'h0100_0000, 40, 32'h0);
        idle(1);

        // Duplicate selectors: lowest index only
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0020;
        s_ready   = 2'b11;
        s_rdata   = {32'hB, 32'hA};
        exp_q.push_back({1'b0, 32'hA});
        @(negedge clk);
        check("dup_s_valid", 32'(s_valid2), 32'(2'b01));
        check("dup_ready", 32'(mem_ready2), 32'(1));
        check("dup_rdata", mem_rdata2, 32'hA);
        @(posedge clk); #1;
        mem_addr = 32'h0100_0020;
        exp_q.push_back({1'b0, 32'hB});
        @(negedge clk);
        check("dup_unmapped_s_valid", 32'(s_valid2), 32'(0));
        check("dup_unmapped_ready", 32'(mem_ready2), 32'(0));
        check("main_ram_s_valid", 32'(s_valid), 32'(2'b10));
        @(posedge clk); #1;
        mem_valid = 1'b0;
        s_ready   = 2'b00;
        @(negedge clk);
        check("dup_err_bus_err", 32'(bus_err2), 32'(1));
        check("dup_err_rdata", mem_rdata2, ERRD);
        @(posedge clk); #1;
        idle(1);

        // Reset in the middle of a wait
        check("pre_rst_cnt", 32'(err_count), 32'(4));
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0008;
        s_ready   = 2'b00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pre_rst_s_valid", 32'(s_valid), 32'(2'b01));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_s_valid", 32'(s_valid), 32'(0));
        check("mid_rst_ready", 32'(mem_ready), 32'(0));
        check("mid_rst_rdata", mem_rdata, 32'h0);
        check("mid_rst_err_count", 32'(err_count), 32'(0));
        exp_cnt = 16'h0;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        rst       = 1'b0;
        idle(2);
        check("post_rst_cnt", 32'(err_count), 32'(0));

        // Saturation: preload near the top, then push past it
        force u_dut.err_count_q = 16'hFFFD;
        @(posedge clk); #1;
        release u_dut.err_count_q;
        exp_cnt = 16'hFFFD;
        repeat (4) req(32'h7F00_0000, 0, 32'h0);
        idle(2);
        check("saturated", 32'(err_count), 32'(16'hFFFF));

        req(32'h0000_0010, 0, 32'h99);
        idle(2);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
